// File: rtl/valu_dot_seq.sv
// Dot-product sequencer: streams N operand word pairs into an external valu and
// accumulates its per-beat signed sums into a wrapping accumulator with sticky overflow.
module valu_dot_seq #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_clear_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [31:0]      op_a_i,
    input  logic [31:0]      op_b_i,
    output logic [31:0]      valu_a_o,
    output logic [31:0]      valu_b_o,
    input  logic [31:0]      valu_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_data_o,
    output logic             res_ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic             r_pipe_v;
    logic [31:0]      r_a, r_b;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_cmd_ready, w_op_ready, w_res_valid;
    logic             w_cmd_fire, w_op_fire;
    logic [ACC_W-1:0] w_addend, w_sum;
    logic             w_sum_ovf;

    // The valu sum fits in 18 signed bits, so truncation to ACC_W (>= 18) is lossless.
    generate
        if (ACC_W <= 32) begin : g_trunc
            assign w_addend = valu_result_i[ACC_W-1:0];
        end else begin : g_sext
            assign w_addend = {{(ACC_W-32){valu_result_i[31]}}, valu_result_i};
        end
    endgenerate

    assign w_sum     = r_acc + w_addend;
    assign w_sum_ovf = (r_acc[ACC_W-1] == w_addend[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    assign w_cmd_fire = cmd_valid_i & w_cmd_ready;
    assign w_op_fire  = op_valid_i & w_op_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Leaving RUN needs only remaining==0: the last beat is then either in the pipe
    // (accumulated on this same edge) or there never was one.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_op_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid_i) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_op_ready = (r_rem != '0);
                if (r_rem == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_res_valid = 1'b1;
                if (res_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rem    <= '0;
            r_pipe_v <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_rem <= cmd_len_i;
                r_ovf <= 1'b0;
                if (cmd_clear_i) r_acc <= '0;
            end else if (r_pipe_v) begin
                r_acc <= w_sum;
                if (w_sum_ovf) r_ovf <= 1'b1;
            end
            // Stall cycles feed zeros so valu output is a clean bubble.
            if (w_op_fire) begin
                r_a      <= op_a_i;
                r_b      <= op_b_i;
                r_pipe_v <= 1'b1;
                r_rem    <= r_rem - 1'b1;
            end else begin
                r_a      <= '0;
                r_b      <= '0;
                r_pipe_v <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = w_cmd_ready;
    assign op_ready_o  = w_op_ready;
    assign res_valid_o = w_res_valid;
    assign res_data_o  = w_res_valid ? r_acc : '0;
    assign res_ovf_o   = w_res_valid & r_ovf;
    assign busy_o      = (r_state != S_IDLE);
    assign valu_a_o    = r_a;
    assign valu_b_o    = r_b;

endmodule

// File: tb/tb_valu_dot_seq.sv
// Bench for valu_dot_seq: directed table of commands, reset/backpressure sequences and
// randomized commands checked against an arithmetic dot-product/accumulator model.
module tb_valu_dot_seq;
    localparam int LEN_W = 8;
    localparam int ACC_W = 18;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0, cmd_clear = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             op_valid = 1'b0;
    logic [31:0]      op_a = '0, op_b = '0;
    logic             res_ready = 1'b0;
    logic             cmd_ready, op_ready, res_valid, res_ovf, busy;
    logic [31:0]      valu_a, valu_b, valu_result;
    logic [ACC_W-1:0] res_data;

    int n_chk = 0, n_fail = 0;
    logic [31:0] ga [256];
    logic [31:0] gb [256];

    always #5 clk = ~clk;

    function automatic int dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        return s;
    endfunction

    // Behavioural stand-in for the external valu datapath.
    assign valu_result = dot(valu_a, valu_b);

    valu_dot_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len), .cmd_clear_i(cmd_clear),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
        .valu_a_o(valu_a), .valu_b_o(valu_b), .valu_result_i(valu_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .res_ovf_o(res_ovf), .busy_o(busy)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int wrap(input longint s);
        longint m = (64'sd1 <<< ACC_W) - 1;
        longint w = s & m;
        if (w >= (64'sd1 <<< (ACC_W-1))) w -= (64'sd1 <<< ACC_W);
        return int'(w);
    endfunction

    task automatic run_cmd(input int len, input bit clr, input int gap, input int hold, input bit junk,
                           output int data, output bit ovf, output int lat);
        bit stable = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = len[LEN_W-1:0]; cmd_clear = clr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            int t = 0;
            repeat (gap) @(negedge clk);
            @(negedge clk);
            op_valid = 1'b1; op_a = ga[i]; op_b = gb[i];
            while (!op_ready && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) chk("op_ready_timeout", 0, 1);
            @(posedge clk); #1;
            if (junk && i == len-1) begin op_a = 32'h7F7F7F7F; op_b = 32'h7F7F7F7F; end
            else op_valid = 1'b0;
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (junk) chk("op_ready_after_last", op_ready, 0);
        end
        data = int'($signed(res_data));
        ovf  = res_ovf;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            if (res_valid !== 1'b1 || int'($signed(res_data)) != data || res_ovf !== ovf ||
                cmd_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        cmd_valid = 1'b0;
        if (hold > 0) chk("hold_stable", stable, 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        op_valid  = 1'b0;
        chk("idle_after_handshake", {busy, cmd_ready}, 2'b01);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_op_ready"},  op_ready,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"},  res_data,  0);
        chk({tag, "_res_ovf"},   res_ovf,   0);
        chk({tag, "_valu_ab"},   {valu_a, valu_b}, 0);
    endtask

    typedef struct {
        int          len;
        bit          clr;
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        int          hold;
        bit          junk;
        int          exp;
        bit          eovf;
    } vec_t;

    vec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d, l, mdl_acc;
        bit o, mdl_ovf;

        // Directed table; each command repeats one operand pair len times.
        tv[0] = '{1, 1, 32'h01020304, 32'h01010101, 0, 0,  0, 10,      0};
        tv[1] = '{1, 1, 32'h80808080, 32'h80808080, 0, 0,  0, 65536,   0};
        tv[2] = '{1, 1, 32'h80808080, 32'h7F7F7F7F, 0, 0,  0, -65024,  0};
        tv[3] = '{3, 1, 32'h01010101, 32'h02020202, 2, 0,  1, 24,      0};
        tv[4] = '{1, 0, 32'h01010101, 32'hFFFFFFFF, 0, 0,  0, 20,      0};
        tv[5] = '{0, 0, 32'h0,        32'h0,        0, 0,  0, 20,      0};
        tv[6] = '{0, 1, 32'h0,        32'h0,        0, 0,  0, 0,       0};
        // 2 x 65536 = 2^17 wraps to -2^17 in an 18-bit accumulator.
        tv[7] = '{2, 1, 32'h80808080, 32'h80808080, 0, 0,  0, -131072, 1};
        tv[8] = '{1, 1, 32'h01020304, 32'h01010101, 0, 10, 0, 10,      0};
        tv[9] = '{2, 0, 32'h7F7F7F7F, 32'h7F7F7F7F, 1, 2,  0, 129042,  0};

        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;

        foreach (tv[k]) begin
            for (int i = 0; i < tv[k].len; i++) begin ga[i] = tv[k].a; gb[i] = tv[k].b; end
            run_cmd(tv[k].len, tv[k].clr, tv[k].gap, tv[k].hold, tv[k].junk, d, o, l);
            chk($sformatf("tv%0d_data", k), d, tv[k].exp);
            chk($sformatf("tv%0d_ovf", k), o, tv[k].eovf);
            chk($sformatf("tv%0d_latency", k), l, 2);
        end

        // Reset after the first of three beats discards the command and the accumulator.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 8'd3; cmd_clear = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_a = 32'h05050505; op_b = 32'h05050505;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outs("midrun_async");
        @(negedge clk);
        chk_reset_outs("midrun_next");
        rst = 1'b0;
        ga[0] = 32'h01020304; gb[0] = 32'h01010101;
        run_cmd(1, 0, 0, 0, 0, d, o, l);
        chk("post_reset_continue", d, 10);

        // Randomized commands against the arithmetic model.
        mdl_acc = 0; mdl_ovf = 0;
        for (int k = 0; k < 40; k++) begin
            int len = (k == 20) ? 255 : int'($urandom_range(0, 6));
            bit clr = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (clr) mdl_acc = 0;
            mdl_ovf = 0;
            for (int i = 0; i < len; i++) begin
                longint s;
                ga[i] = $urandom; gb[i] = $urandom;
                s = longint'(mdl_acc) + longint'(dot(ga[i], gb[i]));
                if (s > (64'sd1 <<< (ACC_W-1)) - 1 || s < -(64'sd1 <<< (ACC_W-1))) mdl_ovf = 1;
                mdl_acc = wrap(s);
            end
            run_cmd(len, clr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), d, o, l);
            chk($sformatf("rnd%0d_data", k), d, mdl_acc);
            chk($sformatf("rnd%0d_ovf", k), o, mdl_ovf);
            chk($sformatf("rnd%0d_latency", k), l, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
